// File: rtl/top_system_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply engine.
//   DATA_W_DEF : default operand/result width
//   state_t    : control FSM states
//   E_W / K_W  : widths of the element index (0..3) and MAC step (0..1)
package top_system_pkg;
  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned E_W        = 2;
  localparam int unsigned K_W        = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/top_system_mac_unit.sv
// Single multiply-accumulate lane.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous accumulator clear
//   en         : load accumulator with the current sum
//   first      : first step of a dot product (ignore old accumulator)
//   a, b       : DATA_W operands
//   res        : current sum truncated to DATA_W (combinational)
module mac_unit #(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              first,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res
);
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] sum;

  // Full-width product; only the final result is truncated.
  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign sum  = first ? prod : acc + prod;
  assign res  = sum[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end
endmodule

// File: rtl/top_system.sv
// 2x2 matrix-multiply engine: C = A x B from elaboration-time operands,
// one MAC per clock, runs once after each reset release.
//   clk, rst_n  : clock, async active-low reset
//   r1..r4      : C00, C01, C10, C11 (registered, modulo 2^DATA_W)
//   end_process : all results valid; held until reset
module top_system
  import top_system_pkg::*;
#(
  parameter int unsigned       DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] A00 = DATA_W'(1),
  parameter logic [DATA_W-1:0] A01 = DATA_W'(2),
  parameter logic [DATA_W-1:0] A10 = DATA_W'(3),
  parameter logic [DATA_W-1:0] A11 = DATA_W'(4),
  parameter logic [DATA_W-1:0] B00 = DATA_W'(5),
  parameter logic [DATA_W-1:0] B01 = DATA_W'(6),
  parameter logic [DATA_W-1:0] B10 = DATA_W'(7),
  parameter logic [DATA_W-1:0] B11 = DATA_W'(8)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic              end_process
);
  state_t                   state;
  logic [E_W-1:0]           e;
  logic [K_W-1:0]           k;
  logic [3:0][DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]        op_a, op_b, mac_res;
  logic                     i_sel, j_sel;

  // Element e = 2i + j.
  assign i_sel = e[1];
  assign j_sel = e[0];

  // A[i][k] and B[k][j]
  always_comb begin
    op_a = '0;
    op_b = '0;
    case ({i_sel, k})
      2'b00: op_a = A00;
      2'b01: op_a = A01;
      2'b10: op_a = A10;
      2'b11: op_a = A11;
      default: op_a = '0;
    endcase
    case ({k, j_sel})
      2'b00: op_b = B00;
      2'b01: op_b = B01;
      2'b10: op_b = B10;
      2'b11: op_b = B11;
      default: op_b = '0;
    endcase
  end

  mac_unit #(.DATA_W(DATA_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .en    (state == CALC),
    .first (k == 1'b0),
    .a     (op_a),
    .b     (op_b),
    .res   (mac_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      e           <= '0;
      k           <= '0;
      r_q         <= '0;
      end_process <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= CALC;
          e     <= '0;
          k     <= '0;
        end
        CALC: begin
          if (k == 1'b0) begin
            k <= 1'b1;
          end else begin
            // Second step: mac_res already holds acc + A[i][1]*B[1][j].
            r_q[e] <= mac_res;
            k      <= 1'b0;
            if (e == E_W'(3)) begin
              state       <= DONE;
              end_process <= 1'b1;
            end else begin
              e <= e + E_W'(1);
            end
          end
        end
        DONE: ;  // terminal until reset
        default: state <= IDLE;
      endcase
    end
  end

  assign r1 = r_q[0];
  assign r2 = r_q[1];
  assign r3 = r_q[2];
  assign r4 = r_q[3];
endmodule

// File: tb/tb_top_system.sv
// Scoreboard bench for top_system: three instances (defaults, all-64
// overflow, 4095*4095 wrap) share clk/rst_n. Per edge the expected outputs
// of each instance are pushed and then popped against the DUT #1 later.
module tb_top_system;
  logic clk, rst_n;
  logic [11:0] o_r1 [3];
  logic [11:0] o_r2 [3];
  logic [11:0] o_r3 [3];
  logic [11:0] o_r4 [3];
  logic        o_ep [3];

  int pa [3][4] = '{'{1, 2, 3, 4}, '{64, 64, 64, 64}, '{4095, 0, 0, 0}};
  int pb [3][4] = '{'{5, 6, 7, 8}, '{64, 64, 64, 64}, '{4095, 0, 0, 0}};

  typedef struct {
    int                 inst;
    int                 edge_n;
    logic [3:0][11:0]   r;
    logic               ep;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  top_system u_dut0 (.clk(clk), .rst_n(rst_n), .r1(o_r1[0]), .r2(o_r2[0]),
                     .r3(o_r3[0]), .r4(o_r4[0]), .end_process(o_ep[0]));
  top_system #(.A00(12'd64), .A01(12'd64), .A10(12'd64), .A11(12'd64),
               .B00(12'd64), .B01(12'd64), .B10(12'd64), .B11(12'd64))
    u_dut1 (.clk(clk), .rst_n(rst_n), .r1(o_r1[1]), .r2(o_r2[1]),
            .r3(o_r3[1]), .r4(o_r4[1]), .end_process(o_ep[1]));
  top_system #(.A00(12'd4095), .A01(12'd0), .A10(12'd0), .A11(12'd0),
               .B00(12'd4095), .B01(12'd0), .B10(12'd0), .B11(12'd0))
    u_dut2 (.clk(clk), .rst_n(rst_n), .r1(o_r1[2]), .r2(o_r2[2]),
            .r3(o_r3[2]), .r4(o_r4[2]), .end_process(o_ep[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // C[e] of instance n, modulo 2^12.
  function automatic logic [11:0] c_elem(int n, int e);
    int i, j;
    longint s;
    i = e / 2;
    j = e % 2;
    s = longint'(pa[n][2*i]) * pb[n][j] + longint'(pa[n][2*i+1]) * pb[n][2+j];
    return 12'(s % 4096);
  endfunction

  // Expected outputs after 'en' edges since reset release (0 = in/at reset).
  task automatic push_exp(int en);
    exp_t x;
    for (int n = 0; n < 3; n++) begin
      x.inst   = n;
      x.edge_n = en;
      for (int e = 0; e < 4; e++)
        x.r[e] = (en >= 3 + 2*e) ? c_elem(n, e) : 12'd0;
      x.ep = (en >= 9);
      sb.push_back(x);
    end
  endtask

  task automatic pop_cmp(string ph);
    exp_t x;
    while (sb.size() != 0) begin
      x = sb.pop_front();
      chk($sformatf("%s.i%0d.e%0d.r1", ph, x.inst, x.edge_n), 32'(o_r1[x.inst]), 32'(x.r[0]));
      chk($sformatf("%s.i%0d.e%0d.r2", ph, x.inst, x.edge_n), 32'(o_r2[x.inst]), 32'(x.r[1]));
      chk($sformatf("%s.i%0d.e%0d.r3", ph, x.inst, x.edge_n), 32'(o_r3[x.inst]), 32'(x.r[2]));
      chk($sformatf("%s.i%0d.e%0d.r4", ph, x.inst, x.edge_n), 32'(o_r4[x.inst]), 32'(x.r[3]));
      chk($sformatf("%s.i%0d.e%0d.ep", ph, x.inst, x.edge_n), 32'(o_ep[x.inst]), 32'(x.ep));
    end
  endtask

  task automatic run(int n, string ph);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
      push_exp(edge_n);
      #1;
      pop_cmp(ph);
    end
  endtask

  // Assert reset away from a clock edge and check the outputs clear at once.
  task automatic async_reset(string ph);
    #2 rst_n = 1'b0;
    edge_n = 0;
    push_exp(0);
    #1;
    pop_cmp(ph);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    push_exp(0);
    pop_cmp("rst");
    @(negedge clk) rst_n = 1'b1;
    edge_n = 0;

    run(9, "run1");
    run(1000, "hold");

    async_reset("rst_done");
    run(9, "run2");

    async_reset("rst_pre");
    run(5, "mid");
    async_reset("rst_mid");
    run(9, "run3");
    run(4, "tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
